// File: rtl/soc_now_pkg.sv
// Shared types and constants for the boot-time program loader.
package soc_now_pkg;

  // Loader FSM: collect a word, write it, or sit finished with the core running.
  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

  // UART receiver frame position.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Marker word that ends a program image; never stored.
  localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;

  // 8N1 framing.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/prog_loader_ctrl_if.sv
// Instruction-memory write port: loader is master, ICCM side is slave.
interface prog_loader_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;

  modport master (output mem_req_o, output mem_addr_o, output mem_wdata_o, input mem_gnt_i);
  modport slave  (input mem_req_o, input mem_addr_o, input mem_wdata_o, output mem_gnt_i);
endinterface

// File: rtl/prog_uart_rx.sv
// 8N1 UART receiver with run-time bit period. byte_valid_o is combinational
// in the cycle of a good stop-bit sample so the loader can react on that edge.
module prog_uart_rx
  import soc_now_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_i,
  input  logic [15:0] clk_per_bit_i,
  output logic        byte_valid_o,
  output logic [7:0]  byte_data_o
);

  logic        sync1_q, sync2_q, prev_q;
  rx_state_e   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] per_q, per_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        sample;

  assign sample      = (cnt_q == 16'd0);
  assign byte_data_o = sh_q;

  // Synchroniser, edge history and frame state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Frame sequencing: half-period to the start-bit centre, then full periods.
  always_comb begin
    st_d         = st_q;
    per_d        = per_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    byte_valid_o = 1'b0;
    cnt_d        = (st_q != RX_IDLE && !sample) ? cnt_q - 16'd1 : cnt_q;
    case (st_q)
      RX_IDLE: begin
        // Period is latched here so a mid-frame change cannot skew the samples.
        if (prev_q && !sync2_q && clk_per_bit_i >= 16'd2) begin
          per_d = clk_per_bit_i;
          cnt_d = (clk_per_bit_i >> 1) - 16'd1;
          st_d  = RX_START;
        end
      end
      RX_START: begin
        if (sample) begin
          if (sync2_q) begin
            st_d = RX_IDLE;            // line back high: glitch, not a start bit
          end else begin
            cnt_d = per_q - 16'd1;
            bit_d = '0;
            st_d  = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (sample) begin
          sh_d  = {sync2_q, sh_q[7:1]};  // LSB arrives first
          cnt_d = per_q - 16'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            st_d  = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        if (sample) begin
          if (!sync2_q) begin
            st_d = RX_IDLE;            // framing error: byte dropped silently
          end else if (bit_q == 3'(STOP_BITS - 1)) begin
            byte_valid_o = 1'b1;
            st_d         = RX_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
            cnt_d = per_q - 16'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot loader: packs UART bytes little-endian into words, writes them to the
// ICCM over req/gnt and releases the core when the end marker arrives.
module prog_loader_ctrl
  import soc_now_pkg::*;
#(
  parameter int          ADDR_W   = 13,
  parameter logic [31:0] END_WORD = END_WORD_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_i,
  input  logic [15:0]               clk_per_bit_i,
  prog_loader_ctrl_if.master        mem,
  output logic                      core_rst_o,
  output logic                      done_o,
  output logic [1:0]                err_o
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  loader_state_e     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       full_word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_q, req_d;
  logic [1:0]        err_q, err_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;

  prog_uart_rx u_rx (
    .clock         (clock),
    .reset         (reset),
    .rx_i          (rx_i),
    .clk_per_bit_i (clk_per_bit_i),
    .byte_valid_o  (byte_valid),
    .byte_data_o   (byte_data)
  );

  // Word as it will look once the incoming byte lands in the top lane.
  assign full_word = {byte_data, word_q[23:0]};

  assign mem.mem_req_o   = req_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign core_rst_o      = core_rst_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RECV;
      cnt_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      err_q      <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
    end
  end

  // Next state: a 4th byte ends a word, a grant ends a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RECV:
        if (byte_valid && cnt_q == 2'd3)
          state_d = (full_word == END_WORD) ? ST_DONE : ST_WRITE;
      ST_WRITE:
        if (mem.mem_gnt_i)
          state_d = (addr_q == {ADDR_W{1'b1}}) ? ST_DONE : ST_RECV;
      default: state_d = ST_DONE;
    endcase
  end

  // Packing, memory handshake and status outputs.
  always_comb begin
    cnt_d      = cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    err_d      = err_q;
    case (state_q)
      ST_RECV: begin
        if (byte_valid) begin
          word_d[8*cnt_q +: 8] = byte_data;
          cnt_d                = cnt_q + 2'd1;
          if (cnt_q == 2'd3 && full_word != END_WORD) begin
            wdata_d = full_word;
            req_d   = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // One byte of the next word may be parked while the write is pending.
        if (byte_valid) begin
          if (cnt_q == 2'd0) begin
            word_d[7:0] = byte_data;
            cnt_d       = 2'd1;
          end else begin
            err_d[0] = 1'b1;
          end
        end
        if (mem.mem_gnt_i) begin
          req_d = 1'b0;
          if (addr_q == {ADDR_W{1'b1}}) err_d[1] = 1'b1;
          else                          addr_d   = addr_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Registered from the next state so release lands one cycle after entry.
    core_rst_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: directed tables, multi-cycle corner sequences and
// a randomized load compared against an in-order list of expected writes.
module tb_prog_loader_ctrl;
  import soc_now_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] per = 16'd16;
  logic        gnt_val = 1'b0, rand_gnt = 1'b0, rnd_bit = 1'b0;
  logic        core_rst, done, core_rst2, done2;
  logic [1:0]  err, err2;

  always #5 clk = ~clk;

  prog_loader_ctrl_if #(.ADDR_W(13)) mif ();
  prog_loader_ctrl_if #(.ADDR_W(2))  mif2 ();

  assign mif.mem_gnt_i  = rand_gnt ? rnd_bit : gnt_val;
  assign mif2.mem_gnt_i = gnt_val;

  prog_loader_ctrl #(.ADDR_W(13)) dut (
    .clock(clk), .reset(rst), .rx_i(rx), .clk_per_bit_i(per), .mem(mif.master),
    .core_rst_o(core_rst), .done_o(done), .err_o(err));

  prog_loader_ctrl #(.ADDR_W(2)) dut2 (
    .clock(clk), .reset(rst), .rx_i(rx), .clk_per_bit_i(per), .mem(mif2.master),
    .core_rst_o(core_rst2), .done_o(done2), .err_o(err2));

  typedef struct packed {logic [12:0] addr; logic [31:0] data;} wr_t;
  wr_t wq[$];
  wr_t wq2[$];

  int cyc = 0;
  int fall_cyc = -1;
  int last_start = 0;
  logic core_rst_prev = 1'b1;
  int pass_cnt = 0, tot = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  // Write monitors: a transfer happens on each edge with req and gnt high.
  always @(posedge clk) begin
    if (!rst && mif.mem_req_o && mif.mem_gnt_i)   wq.push_back({mif.mem_addr_o, mif.mem_wdata_o});
    if (!rst && mif2.mem_req_o && mif2.mem_gnt_i) wq2.push_back({13'(mif2.mem_addr_o), mif2.mem_wdata_o});
  end

  always @(negedge clk) begin
    if (core_rst_prev && !core_rst) fall_cyc <= cyc;
    core_rst_prev <= core_rst;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic chk_wr(input int i, input logic [12:0] a, input logic [31:0] d, input bit second);
    wr_t w;
    int  sz;
    sz = second ? wq2.size() : wq.size();
    if (i >= sz) begin
      tot++;
      $display("FAIL write%0d: missing, got %0d writes expected more", i, sz);
    end else begin
      w = second ? wq2[i] : wq[i];
      chk($sformatf("write%0d_addr", i), 32'(w.addr), 32'(a));
      chk($sformatf("write%0d_data", i), w.data, d);
    end
  endtask

  // One 8N1 frame, per cycles per bit, driven on falling edges.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = fr[i];
      if (i == 0) last_start = cyc;
      repeat (int'(per) - 1) @(negedge clk);
    end
    if (!stop_ok) begin
      @(negedge clk);
      rx = 1'b1;
      repeat (int'(per)) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    wq2.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tot++;
      $display("FAIL wait_done: done_o still %b after %0d cycles, expected 1", done, budget);
    end
  endtask

  typedef struct {logic [7:0] b0, b1, b2, b3; logic [31:0] exp;} vec_t;
  vec_t tbl[5];

  initial begin
    logic [12:0] a_hold;
    logic [31:0] d_hold, w;
    logic [31:0] exp_q[$];
    bit          stable;
    int          n;

    // Bytes in arrival order; expected word written by hand, little-endian.
    tbl[0] = '{8'h13, 8'h05, 8'h00, 8'h00, 32'h0000_0513};
    tbl[1] = '{8'hB3, 8'h05, 8'hB5, 8'h00, 32'h00B5_05B3};
    tbl[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF};
    tbl[3] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678};
    tbl[4] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 32'h0000_0FFF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mif.mem_req_o), 0);
    chk("rst_addr", 32'(mif.mem_addr_o), 0);
    chk("rst_wdata", mif.mem_wdata_o, 0);
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    wq.delete();
    wq2.delete();

    // Table load, grant tied high
    per = 16'd16;
    gnt_val = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send_byte(tbl[i].b0); send_byte(tbl[i].b1);
      send_byte(tbl[i].b2); send_byte(tbl[i].b3);
    end
    wait_done(200);
    chk("tbl_nwrites", 32'(wq.size()), 4);
    for (int i = 0; i < 4; i++) chk_wr(i, 13'(i), tbl[i].exp, 1'b0);
    // 2 sync flops + edge register, half a bit to the start centre, 9 bits more.
    chk("tbl_rst_latency", 32'(fall_cyc - last_start), 32'(3 + int'(per) / 2 + 9 * int'(per)));
    chk("tbl_core_rst", 32'(core_rst), 0);
    chk("tbl_err", 32'(err), 0);
    send_word(32'hA5A5_A5A5);
    repeat (20) @(negedge clk);
    chk("done_ignores_bytes", 32'(wq.size()), 4);
    chk("done_sticky", 32'(done), 1);

    // Backpressure: grant withheld for 40 cycles
    do_reset();
    gnt_val = 1'b0;
    send_word(32'hCAFE_0001);
    n = 0;
    while (!mif.mem_req_o && n < 50) begin @(negedge clk); n++; end
    a_hold = 13'(mif.mem_addr_o);
    d_hold = mif.mem_wdata_o;
    stable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (!mif.mem_req_o || mif.mem_addr_o !== a_hold || mif.mem_wdata_o !== d_hold) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    chk("bp_hold_addr", 32'(a_hold), 0);
    chk("bp_hold_data", d_hold, 32'hCAFE_0001);
    gnt_val = 1'b1;
    @(negedge clk);
    gnt_val = 1'b0;
    @(negedge clk);
    chk("bp_req_drop", 32'(mif.mem_req_o), 0);
    chk("bp_one_write", 32'(wq.size()), 1);
    gnt_val = 1'b1;
    send_word(32'h0000_0002);
    repeat (30) @(negedge clk);
    chk_wr(1, 13'd1, 32'h0000_0002, 1'b0);

    // Overrun: two bytes arrive while the write is still pending
    do_reset();
    per = 16'd4;
    gnt_val = 1'b0;
    send_word(32'h1122_3344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (10) @(negedge clk);
    chk("ovr_err", 32'(err), 32'h1);
    chk("ovr_no_write", 32'(wq.size()), 0);
    gnt_val = 1'b1;
    send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    repeat (12) @(negedge clk);
    chk_wr(0, 13'd0, 32'h1122_3344, 1'b0);
    chk_wr(1, 13'd1, 32'hEEDD_CCAA, 1'b0);
    chk("ovr_err_sticky", 32'(err), 32'h1);

    // Framing error, 1-cycle glitch and a too-short bit period all yield no byte
    do_reset();
    per = 16'd16;
    send_byte(8'h11);
    send_byte(8'h99, 1'b0);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    per = 16'd1;
    send_byte(8'h77);
    per = 16'd16;
    repeat (5) @(negedge clk);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (20) @(negedge clk);
    chk("frm_nwrites", 32'(wq.size()), 1);
    chk_wr(0, 13'd0, 32'h4433_2211, 1'b0);
    chk("frm_err", 32'(err), 0);

    // Memory full on the 4-word instance
    do_reset();
    per = 16'd8;
    send_word(32'h0000_0001); send_word(32'h0000_0002);
    send_word(32'h0000_0003); send_word(32'h0000_0004);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_wr(i, 13'(i), 32'(i + 1), 1'b1);
    chk("full_nwrites", 32'(wq2.size()), 4);
    chk("full_err", 32'(err2), 32'h2);
    chk("full_done", 32'(done2), 1);
    chk("full_core_rst", 32'(core_rst2), 0);
    chk("big_not_done", 32'(done), 0);

    // Asynchronous reset part-way through a load
    do_reset();
    send_word(32'h0BAD_F00D);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (2) @(negedge clk);
    chk("mid_addr_before", 32'(mif.mem_addr_o), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_req", 32'(mif.mem_req_o), 0);
    chk("mid_addr", 32'(mif.mem_addr_o), 0);
    chk("mid_wdata", mif.mem_wdata_o, 0);
    chk("mid_core_rst", 32'(core_rst), 1);
    chk("mid_err_done", {30'd0, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    repeat (3) @(negedge clk);
    send_word(32'h0000_1234);
    send_word(END_WORD_DEF);
    wait_done(200);
    chk("mid_nwrites", 32'(wq.size()), 1);
    chk_wr(0, 13'd0, 32'h0000_1234, 1'b0);

    // Randomized load: random words, bit periods and grant timing
    do_reset();
    rand_gnt = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      if (w == END_WORD_DEF) w = w ^ 32'h1;
      exp_q.push_back(w);
      for (int i = 0; i < 4; i++) begin
        per = 16'($urandom_range(4, 12));
        send_byte(w[8*i +: 8]);
      end
    end
    send_word(END_WORD_DEF);
    wait_done(500);
    rand_gnt = 1'b0;
    chk("rnd_nwrites", 32'(wq.size()), 8);
    for (int k = 0; k < 8; k++) chk_wr(k, 13'(k), exp_q[k], 1'b0);
    chk("rnd_err", 32'(err), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
- Boot-time programming controller for the SoC's instruction memory.
- Receives bytes on the programming UART pin at a run-time bit period, packs them little-endian into 32-bit words, and writes each word to instruction memory through a req/gnt handshake.
- Holds the core in reset until the end-of-program marker arrives, then releases it.
- Sits between the user-area pad and the core/ICCM inside the SoC top.

Parameters:
- ADDR_W, 13, word-address width of instruction memory (depth 2^ADDR_W words).
- END_WORD, 32'h0000_0FFF, end-of-program marker word; it is never written to memory.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_i  in  1  raw UART RX pin, asynchronous to clock
- clk_per_bit_i  in  16  UART bit period in clock cycles
- mem_req_o  out  1  write request
- mem_gnt_i  in  1  write accepted this cycle
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  32  write data
- core_rst_o  out  1  core reset, active-high
- done_o  out  1  program load complete
- err_o  out  2  sticky flags: [0] byte overrun, [1] memory full

Behaviour:
- Reset values: mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1, done_o=0, err_o=0. All internal state clears, including the FSM (goes to RECV), the synchroniser (both stages set to 1), byte count and word address.
- Reset asserted mid-load aborts the load; the next load restarts at address 0.
- rx_i passes through a 2-FF synchroniser before any use.
- UART receive, 8N1, LSB first:
  - A start bit is a synchronised falling edge while the receiver is idle.
  - Sample at clk_per_bit/2 after the edge; if the line is high, treat it as a glitch and return to idle.
  - Then sample 8 data bits and the stop bit at clk_per_bit intervals.
  - Stop bit 0 is a framing error: drop the byte silently.
  - A good byte gives a 1-cycle byte_valid.
  - clk_per_bit_i < 2 keeps the receiver idle.
  - clk_per_bit_i is sampled at the start edge and held for the whole frame.
- FSM states RECV, WRITE, DONE:
  - RECV: on byte_valid, shift the byte into word[8*cnt +: 8] and increment the 2-bit cnt.
  - On the 4th byte (cnt wraps 3->0): if the word == END_WORD, go to DONE. Otherwise load mem_wdata_o, assert mem_req_o and go to WRITE.
  - WRITE: hold mem_req_o, mem_addr_o and mem_wdata_o stable until mem_gnt_i=1. mem_gnt_i in the same cycle as req completes the write.
  - On grant (1 transfer per grant): deassert mem_req_o next cycle. If mem_addr_o == 2^ADDR_W-1, set err_o[1] and go to DONE. Otherwise increment mem_addr_o and return to RECV.
  - A byte_valid arriving in WRITE is latched into the next word, but only when cnt==0; a second byte before the grant sets err_o[0] and is dropped.
  - DONE: core_rst_o=0 and done_o=1 from the first cycle after entry. Terminal until reset; further UART bytes are ignored.
- Grant asserted outside WRITE is ignored.
- Latencies:
  - Last stop-bit sample to mem_req_o: 1 cycle.
  - END_WORD completion to core_rst_o falling: 1 cycle.

Decomposition:
- Shared package soc_now_pkg holds:
  - the loader FSM state enum;
  - END_WORD default;
  - UART frame constants (DATA_BITS=8, STOP_BITS=1).
- One sub-module, prog_uart_rx: synchroniser, bit-period counter and shift register, producing byte_valid/byte_data.
- prog_loader_ctrl instantiates it and owns packing, the FSM and the memory handshake.

Test Plan:
- Load with clk_per_bit_i=16, mem_gnt_i tied 1. Send bytes 13 05 00 00, B3 05 B5 00, FF 0F 00 00 -> writes 32'h0000_0513 @0 and 32'h00B5_05B3 @1; core_rst_o falls 1 cycle after the last stop-bit sample; done_o=1.
- Backpressure: mem_gnt_i delayed 40 cycles -> mem_req_o, addr and data stay stable for 40 cycles; exactly one write; next word lands at addr 1.
- Overrun: clk_per_bit_i=4 with mem_gnt_i held 0 over 2 full bytes -> first byte kept, second dropped, err_o[0]=1, and it stays 1 after the grant.
- Framing and glitch: stop bit 0 on one byte -> byte dropped, no cnt change. A 1-cycle low pulse on rx_i -> no byte.
- Full: ADDR_W=2, send 4 non-marker words -> writes @0..3, err_o[1]=1, DONE entered, core_rst_o=0.
- Reset mid-load after 6 bytes: assert reset async -> outputs return to reset values immediately; a fresh load writes from addr 0.
